// File: rtl/kt8_data_port_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// kt8_data_port_if
// Bundles the KT8 data-RAM bus together with the TX and RX byte streams served
// by kt8_data_port.
//   ram_address_i  5  CPU data address
//   ram_data_i     8  CPU write data
//   ram_we_i       1  CPU write strobe
//   ram_data_o     8  read data, combinational from ram_address_i
//   tx_data_o      8  TX FIFO head byte (0 when empty)
//   tx_valid_o     1  TX FIFO non-empty
//   tx_ready_i     1  consumer takes the head when valid & ready
//   rx_data_i      8  incoming byte
//   rx_valid_i     1  incoming byte valid
//   rx_ready_o     1  RX holding register empty
// Modports: slave = the data port itself, master = CPU plus stream partners.
// -----------------------------------------------------------------------------
interface kt8_data_port_if;
  logic [4:0] ram_address_i;
  logic [7:0] ram_data_i;
  logic       ram_we_i;
  logic [7:0] ram_data_o;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready_i;
  logic [7:0] rx_data_i;
  logic       rx_valid_i;
  logic       rx_ready_o;

  modport slave (
    input  ram_address_i, ram_data_i, ram_we_i, tx_ready_i, rx_data_i, rx_valid_i,
    output ram_data_o, tx_data_o, tx_valid_o, rx_ready_o
  );

  modport master (
    output ram_address_i, ram_data_i, ram_we_i, tx_ready_i, rx_data_i, rx_valid_i,
    input  ram_data_o, tx_data_o, tx_valid_o, rx_ready_o
  );
endinterface

// File: rtl/kt8_data_port.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// kt8_data_port
// Memory and I/O responder on the KT8 CPU data bus.
//   0-27 : 28 bytes of RAM
//   28   : TXD    write pushes into the TX FIFO, reads 0
//   29   : STATUS {4'b0, ovf, rx_full, tx_full, tx_empty}; any write clears ovf
//   30   : RXD    RX holding byte; any write acknowledges it
//   31   : TICK   prescaled counter; a write loads it and restarts the prescaler
// Ports:
//   clk_i  clock, all state on the rising edge
//   rst_i  asynchronous active-low reset
//   bus    kt8_data_port_if.slave (CPU bus, TX stream out, RX stream in)
// Parameters:
//   DEPTH     TX FIFO entries, power of 2, >= 2
//   PRESCALE  clk cycles per TICK increment, >= 2
// -----------------------------------------------------------------------------
module kt8_data_port #(
  parameter int DEPTH    = 4,
  parameter int PRESCALE = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  kt8_data_port_if.slave  bus
);

  localparam int RAM_WORDS = 28;
  localparam int PTR_W     = $clog2(DEPTH);
  localparam int CNT_W     = $clog2(DEPTH + 1);
  localparam int PS_W      = $clog2(PRESCALE);

  typedef enum logic [4:0] {
    ADDR_TXD    = 5'd28,
    ADDR_STATUS = 5'd29,
    ADDR_RXD    = 5'd30,
    ADDR_TICK   = 5'd31
  } io_addr_e;

  // State
  logic [7:0]       ram  [RAM_WORDS];
  logic [7:0]       fifo [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic             rx_full;
  logic [7:0]       rx_data;
  logic [7:0]       tick;
  logic [PS_W-1:0]  prescaler;

  // Decoded bus events
  logic is_ram, ram_wr;
  logic tx_valid, tx_full, tx_empty;
  logic pop, push_req, push_ok, ovf_set;
  logic status_wr, rx_ack, capture, tick_wr, ps_wrap;

  assign is_ram    = bus.ram_address_i < 5'(RAM_WORDS);
  assign ram_wr    = bus.ram_we_i & is_ram;

  assign tx_empty  = (count == '0);
  assign tx_full   = (count == CNT_W'(DEPTH));
  assign tx_valid  = ~tx_empty;
  assign pop       = tx_valid & bus.tx_ready_i;
  assign push_req  = bus.ram_we_i & (bus.ram_address_i == ADDR_TXD);
  // A simultaneous pop frees the slot the push needs, so a full FIFO still accepts.
  assign push_ok   = push_req & (~tx_full | pop);
  assign ovf_set   = push_req & ~push_ok;

  assign status_wr = bus.ram_we_i & (bus.ram_address_i == ADDR_STATUS);
  assign rx_ack    = bus.ram_we_i & (bus.ram_address_i == ADDR_RXD);
  assign capture   = bus.rx_valid_i & ~rx_full;
  assign tick_wr   = bus.ram_we_i & (bus.ram_address_i == ADDR_TICK);
  assign ps_wrap   = (prescaler == PS_W'(PRESCALE - 1));

  // Stream outputs come straight from registered state.
  assign bus.tx_valid_o = tx_valid;
  assign bus.tx_data_o  = tx_valid ? fifo[rd_ptr] : 8'h00;
  assign bus.rx_ready_o = ~rx_full;

  // Zero-latency read mux; reads never change state.
  always_comb begin
    // NOTE: default first so every path assigns ram_data_o and no latch is inferred.
    bus.ram_data_o = 8'h00;
    if (is_ram) begin
      bus.ram_data_o = ram[bus.ram_address_i];
    end else begin
      case (bus.ram_address_i)
        ADDR_STATUS: bus.ram_data_o = {4'b0000, ovf, rx_full, tx_full, tx_empty};
        ADDR_RXD:    bus.ram_data_o = rx_data;
        ADDR_TICK:   bus.ram_data_o = tick;
        default:     bus.ram_data_o = 8'h00;  // TXD reads as zero
      endcase
    end
  end

  // RAM: the CPU expects zeroed data memory after reset, so it is cleared here.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      // NOTE: a memory is reset only when software relies on its contents;
      // the FIFO storage below is left unreset because count gates tx_data_o.
      for (int i = 0; i < RAM_WORDS; i++) ram[i] <= 8'h00;
    end else if (ram_wr) begin
      // NOTE: sequential state uses non-blocking assignments only.
      ram[bus.ram_address_i] <= bus.ram_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) fifo[wr_ptr] <= bus.ram_data_i;
  end

  // FIFO pointers and occupancy; pointers wrap naturally because DEPTH is 2^PTR_W.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as a STATUS write keeps it set.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)         ovf <= 1'b0;
    else if (ovf_set)   ovf <= 1'b1;
    else if (status_wr) ovf <= 1'b0;
  end

  // RX holding register. Capture and ack are mutually exclusive: capture
  // needs rx_full low, and ack only matters while it is high.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_full <= 1'b0;
      rx_data <= 8'h00;
    end else if (capture) begin
      rx_full <= 1'b1;
      rx_data <= bus.rx_data_i;
    end else if (rx_ack) begin
      rx_full <= 1'b0;
    end
  end

  // Prescaled tick counter; a CPU load wins over a same-cycle increment.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      prescaler <= '0;
      tick      <= 8'h00;
    end else if (tick_wr) begin
      prescaler <= '0;
      tick      <= bus.ram_data_i;
    end else if (ps_wrap) begin
      prescaler <= '0;
      tick      <= tick + 8'd1;
    end else begin
      prescaler <= prescaler + PS_W'(1);
    end
  end

endmodule

// File: tb/tb_kt8_data_port.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_kt8_data_port
// Directed walk through the data port's behaviour followed by a randomized
// phase. A queue-based reference model tracks RAM, FIFO contents, flags and
// elapsed cycles; TX bytes the model accepts go into a scoreboard that a
// separate monitor drains whenever the DUT hands a byte out.
// -----------------------------------------------------------------------------
module tb_kt8_data_port;

  localparam int DEPTH    = 4;
  localparam int PRESCALE = 16;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  kt8_data_port_if bus ();

  kt8_data_port #(.DEPTH(DEPTH), .PRESCALE(PRESCALE)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_ram [28];
  logic [7:0] m_fifo [$];
  logic [7:0] sb_q [$];
  bit         m_ovf;
  bit         m_rx_full;
  logic [7:0] m_rx_data;
  logic [7:0] m_tick_base;
  int         m_tick_cyc;
  logic [7:0] last_pop = 8'h00;

  task automatic model_reset();
    foreach (m_ram[i]) m_ram[i] = 8'h00;
    m_fifo.delete();
    sb_q.delete();
    m_ovf       = 1'b0;
    m_rx_full   = 1'b0;
    m_rx_data   = 8'h00;
    m_tick_base = 8'h00;
    m_tick_cyc  = 0;
  endtask

  // Effect of one rising edge, from the bus values held across it.
  task automatic model_step();
    logic [4:0] a;
    bit         we, do_pop;
    a      = bus.ram_address_i;
    we     = bus.ram_we_i;
    do_pop = bus.tx_ready_i && (m_fifo.size() != 0);
    if (do_pop) void'(m_fifo.pop_front());
    if (we && a == 5'd28) begin
      if (m_fifo.size() < DEPTH) begin
        m_fifo.push_back(bus.ram_data_i);
        sb_q.push_back(bus.ram_data_i);
      end else begin
        m_ovf = 1'b1;
      end
    end else if (we && a == 5'd29) begin
      m_ovf = 1'b0;
    end
    if (bus.rx_valid_i && !m_rx_full) begin
      m_rx_full = 1'b1;
      m_rx_data = bus.rx_data_i;
    end else if (we && a == 5'd30) begin
      m_rx_full = 1'b0;
    end
    if (we && a == 5'd31) begin
      m_tick_base = bus.ram_data_i;
      m_tick_cyc  = 0;
    end else begin
      m_tick_cyc++;
    end
    if (we && a < 5'd28) m_ram[a] = bus.ram_data_i;
  endtask

  function automatic logic [7:0] exp_read(input logic [4:0] a);
    if (a < 5'd28) return m_ram[a];
    case (a)
      5'd29:   return {4'b0000, m_ovf, m_rx_full,
                       m_fifo.size() == DEPTH, m_fifo.size() == 0};
      5'd30:   return m_rx_data;
      5'd31:   return 8'((int'(m_tick_base) + m_tick_cyc / PRESCALE) % 256);
      default: return 8'h00;
    endcase
  endfunction

  always @(negedge rst_i) model_reset();
  always @(posedge clk_i) if (rst_i) model_step();

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [7:0] exp_b;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        check("tx_valid", 32'(bus.tx_valid_o), 32'(m_fifo.size() != 0));
        check("rx_ready", 32'(bus.rx_ready_o), 32'(!m_rx_full));
        if (bus.tx_valid_o && bus.tx_ready_i) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL tx_pop: got 0x%0h, expected no byte at %0t", bus.tx_data_o, $time);
          end else begin
            exp_b = sb_q.pop_front();
            check("tx_data", 32'(bus.tx_data_o), 32'(exp_b));
          end
          last_pop = bus.tx_data_o;
        end else if (!bus.tx_valid_o) begin
          check("tx_data_idle", 32'(bus.tx_data_o), 32'h0);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Every helper leaves time 1 ns after a rising edge.
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    bus.ram_address_i = a;
    bus.ram_data_i    = d;
    bus.ram_we_i      = 1'b1;
    wait_cyc(1);
    bus.ram_we_i      = 1'b0;
  endtask

  task automatic rd_const(input logic [4:0] a, input logic [7:0] exp, input string name);
    bus.ram_address_i = a;
    #1;
    check(name, 32'(bus.ram_data_o), 32'(exp));
  endtask

  task automatic rd_model(input logic [4:0] a, input string name);
    bus.ram_address_i = a;
    #1;
    check(name, 32'(bus.ram_data_o), 32'(exp_read(a)));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [4:0] a;
    int         budget;

    bus.ram_address_i = 5'd0;
    bus.ram_data_i    = 8'h00;
    bus.ram_we_i      = 1'b0;
    bus.tx_ready_i    = 1'b0;
    bus.rx_data_i     = 8'h00;
    bus.rx_valid_i    = 1'b0;
    model_reset();
    wait_cyc(2);
    rst_i = 1'b1;

    // RAM cleared by reset, then a simple write/read
    for (int i = 0; i < 28; i++) begin
      rd_const(5'(i), 8'h00, "ram_reset");
      if (i % 3 == 2) wait_cyc(1);
    end
    wait_cyc(1);
    wr(5'd3, 8'h5A);
    rd_const(5'd3, 8'h5A, "ram_wr3");
    rd_const(5'd4, 8'h00, "ram_rd4");
    rd_model(5'd29, "status_reset");

    // Fill FIFO, overflow, drain, clear ovf
    wr(5'd28, 8'h11);
    wr(5'd28, 8'h22);
    wr(5'd28, 8'h33);
    wr(5'd28, 8'h44);
    rd_const(5'd29, 8'h02, "status_full");
    wr(5'd28, 8'h55);
    rd_const(5'd29, 8'h0A, "status_ovf");
    rd_const(5'd28, 8'h00, "txd_reads_zero");
    bus.tx_ready_i = 1'b1;
    wait_cyc(4);
    rd_const(5'd29, 8'h09, "status_drained");
    check("drain_last", 32'(last_pop), 32'h44);
    check("drain_sb_empty", 32'(sb_q.size()), 32'h0);
    bus.tx_ready_i = 1'b0;
    wr(5'd29, 8'h00);
    rd_const(5'd29, 8'h01, "status_ovf_cleared");

    // Push into a full FIFO in a pop cycle is accepted
    wr(5'd28, 8'h61);
    wr(5'd28, 8'h62);
    wr(5'd28, 8'h63);
    wr(5'd28, 8'h64);
    bus.tx_ready_i = 1'b1;
    wr(5'd28, 8'h66);
    rd_const(5'd29, 8'h02, "push_pop_full");
    wait_cyc(4);
    check("push_pop_last", 32'(last_pop), 32'h66);
    rd_const(5'd29, 8'h01, "push_pop_drained");
    bus.tx_ready_i = 1'b0;

    // RX capture, hold-off, acknowledge
    check("rx_ready_idle", 32'(bus.rx_ready_o), 32'h1);
    bus.rx_data_i  = 8'hA7;
    bus.rx_valid_i = 1'b1;
    wait_cyc(1);
    check("rx_ready_full", 32'(bus.rx_ready_o), 32'h0);
    rd_const(5'd30, 8'hA7, "rxd_a7");
    rd_const(5'd29, 8'h05, "status_rx_full");
    bus.rx_data_i = 8'hB0;
    wait_cyc(2);
    rd_const(5'd30, 8'hA7, "rxd_held_off");
    wr(5'd30, 8'h00);
    check("rx_ready_ack", 32'(bus.rx_ready_o), 32'h1);
    rd_const(5'd30, 8'hA7, "rxd_after_ack");
    wait_cyc(1);
    rd_const(5'd30, 8'hB0, "rxd_b0");
    check("rx_ready_b0", 32'(bus.rx_ready_o), 32'h0);
    bus.rx_valid_i = 1'b0;
    wr(5'd30, 8'h00);

    // Asynchronous reset mid-cycle with state pending
    wr(5'd28, 8'hC1);
    wr(5'd28, 8'hC2);
    bus.rx_data_i  = 8'h3C;
    bus.rx_valid_i = 1'b1;
    wait_cyc(1);
    bus.rx_valid_i = 1'b0;
    wait_cyc(1);
    #2;
    rst_i = 1'b0;
    #1;
    check("rst_tx_valid", 32'(bus.tx_valid_o), 32'h0);
    check("rst_rx_ready", 32'(bus.rx_ready_o), 32'h1);
    check("rst_tx_data", 32'(bus.tx_data_o), 32'h0);
    rd_const(5'd29, 8'h01, "rst_status");
    rd_const(5'd3, 8'h00, "rst_ram3");
    wait_cyc(2);
    rst_i = 1'b1;

    // Tick counter from reset, then load and wrap
    wait_cyc(80);
    rd_const(5'd31, 8'h05, "tick_80");
    wr(5'd31, 8'hFF);
    rd_const(5'd31, 8'hFF, "tick_load");
    wait_cyc(15);
    rd_const(5'd31, 8'hFF, "tick_hold");
    wait_cyc(1);
    rd_const(5'd31, 8'h00, "tick_wrap");

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      bus.tx_ready_i = 1'($urandom_range(0, 1));
      bus.rx_valid_i = ($urandom_range(0, 3) == 0);
      bus.rx_data_i  = 8'($urandom);
      bus.ram_we_i   = 1'($urandom_range(0, 1));
      bus.ram_data_i = 8'($urandom);
      a = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 27))
                                      : 5'(28 + $urandom_range(0, 3));
      bus.ram_address_i = a;
      #1;
      check("rand_read", 32'(bus.ram_data_o), 32'(exp_read(a)));
      wait_cyc(1);
    end

    // Drain whatever is left, bounded
    bus.ram_we_i   = 1'b0;
    bus.rx_valid_i = 1'b0;
    bus.tx_ready_i = 1'b1;
    budget = 0;
    while (sb_q.size() != 0 && budget < 20) begin
      wait_cyc(1);
      budget++;
    end
    check("final_drain", 32'(sb_q.size()), 32'h0);
    wait_cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
